// File: rtl/fetch_ctrl_if.sv
// Signal bundle around fetch_ctrl: PC register, instruction memory and decode-side handshake.
// master = fetch_ctrl, slave = surrounding pipeline / memory.
interface fetch_ctrl_if;
  logic [31:0] pc_q;
  logic        pc_en;
  logic [31:0] pc_next;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;

  modport master (
    input  pc_q, imem_ack, imem_rdata, stall, redirect, redirect_pc,
    output pc_en, pc_next, imem_req, imem_addr, inst_valid, inst_out, inst_pc
  );

  modport slave (
    output pc_q, imem_ack, imem_rdata, stall, redirect, redirect_pc,
    input  pc_en, pc_next, imem_req, imem_addr, inst_valid, inst_out, inst_pc
  );
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: single-outstanding instruction fetch sequencer between PC register, imem and decode.
// Define FETCH_PERF_EN to add perf_cnt, a wrapping count of instructions accepted by decode.
module fetch_ctrl #(
  parameter logic [31:0] PC_STEP = 32'd4
) (
  input  logic         clk,
  input  logic         rst,
  fetch_ctrl_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]  perf_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD, S_DROP} state_e;

  state_e      r_state;
  state_e      w_next_state;
  logic        r_imem_req;
  logic [31:0] r_imem_addr;
  logic        r_inst_valid;
  logic [31:0] r_inst_out;
  logic [31:0] r_inst_pc;
  logic        w_pc_en;
  logic [31:0] w_pc_next;
  logic        w_accept;

  // Decode takes the held word; a coincident redirect kills it instead.
  assign w_accept = (r_state == S_HOLD) && !bus.stall && !bus.redirect;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_next_state = r_state;
    w_pc_en      = 1'b0;
    w_pc_next    = bus.pc_q;
    if (!rst) begin
      if (bus.redirect) begin
        w_pc_en   = 1'b1;
        w_pc_next = bus.redirect_pc;
      end
      unique case (r_state)
        S_IDLE: if (!bus.redirect) w_next_state = S_WAIT;
        S_WAIT: begin
          if (bus.imem_ack) begin
            if (bus.redirect) begin
              w_next_state = S_IDLE;
            end else begin
              w_next_state = S_HOLD;
              w_pc_en      = 1'b1;
              w_pc_next    = bus.pc_q + PC_STEP;
            end
          end else if (bus.redirect) begin
            w_next_state = S_DROP;
          end
        end
        S_HOLD: begin
          if (bus.redirect)     w_next_state = S_IDLE;
          else if (!bus.stall)  w_next_state = S_WAIT;
        end
        S_DROP: if (bus.imem_ack) w_next_state = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking <= so all registers update from pre-edge values.
    if (rst) begin
      r_state      <= S_IDLE;
      r_imem_req   <= 1'b0;
      r_imem_addr  <= '0;
      r_inst_valid <= 1'b0;
      r_inst_out   <= '0;
      r_inst_pc    <= '0;
    end else begin
      r_state <= w_next_state;
      if (bus.redirect) r_inst_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (!bus.redirect) begin
            r_imem_req  <= 1'b1;
            r_imem_addr <= bus.pc_q;
          end
        end
        S_WAIT: begin
          if (bus.imem_ack) begin
            r_imem_req <= 1'b0;
            if (!bus.redirect) begin
              r_inst_out   <= bus.imem_rdata;
              r_inst_pc    <= r_imem_addr;
              r_inst_valid <= 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (w_accept) begin
            r_inst_valid <= 1'b0;
            r_imem_req   <= 1'b1;
            r_imem_addr  <= bus.pc_q;
          end
        end
        S_DROP: if (bus.imem_ack) r_imem_req <= 1'b0;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst)           perf_cnt <= '0;
    else if (w_accept) perf_cnt <= perf_cnt + 32'd1;
  end
`endif

  assign bus.pc_en      = w_pc_en;
  assign bus.pc_next    = w_pc_next;
  assign bus.imem_req   = r_imem_req;
  assign bus.imem_addr  = r_imem_addr;
  assign bus.inst_valid = r_inst_valid;
  assign bus.inst_out   = r_inst_out;
  assign bus.inst_pc    = r_inst_pc;

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter: PC_STEP, 32'd4, sequential PC increment.
REQ-002 Port: clk  input  1  system clock; all state updates on posedge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: pc_q  input  32  current PC from the downstream 32-bit PC register.
REQ-005 Port: pc_en  output  1  write enable to the PC register; combinational.
REQ-006 Port: pc_next  output  32  next-PC data to the PC register; combinational.
REQ-007 Port: imem_req  output  1  instruction memory request; registered.
REQ-008 Port: imem_addr  output  32  request address; registered.
REQ-009 Port: imem_ack  input  1  memory completion; imem_rdata valid in the same cycle.
REQ-010 Port: imem_rdata  input  32  fetched instruction word.
REQ-011 Port: stall  input  1  decode cannot accept.
REQ-012 Port: redirect  input  1  branch/jump taken; single-cycle pulse.
REQ-013 Port: redirect_pc  input  32  target PC, valid while redirect=1.
REQ-014 Port: inst_valid  output  1  inst_out and inst_pc valid; registered.
REQ-015 Port: inst_out  output  32  held instruction; registered.
REQ-016 Port: inst_pc  output  32  PC of inst_out; registered.

Function
REQ-017 The FSM SHALL have states IDLE, WAIT, HOLD and DROP.
REQ-018 IDLE: the FSM SHALL go to WAIT next cycle and register imem_req=1, imem_addr=pc_q.
REQ-019 WAIT: imem_req and imem_addr SHALL stay stable until imem_ack=1.
REQ-020 WAIT with imem_ack=1 and redirect=0: the block SHALL capture inst_out=imem_rdata, inst_pc=imem_addr and inst_valid=1, assert pc_en=1 with pc_next=pc_q+PC_STEP in that cycle, clear imem_req, and go to HOLD.
REQ-021 HOLD: inst_valid SHALL stay 1 and outputs SHALL stay constant while stall=1.
REQ-022 HOLD with stall=0 (accept): the block SHALL clear inst_valid, register imem_req=1 with imem_addr=pc_q, and go to WAIT.
REQ-023 redirect=1 in any state: the block SHALL drive pc_en=1 and pc_next=redirect_pc in the same cycle, and inst_valid SHALL be 0 next cycle.
REQ-024 redirect=1 in WAIT without imem_ack: the FSM SHALL go to DROP, keeping imem_req and imem_addr unchanged.
REQ-025 redirect=1 in WAIT with imem_ack: the block SHALL discard imem_rdata, clear imem_req, and go to IDLE.
REQ-026 redirect=1 in IDLE or HOLD: the FSM SHALL go to IDLE, and any pending request SHALL not be issued.
REQ-027 DROP: on imem_ack the block SHALL discard data, clear imem_req, and go to IDLE; pc_en SHALL stay 0 unless redirect=1.
REQ-028 Redirect SHALL take priority over stall and over sequential pc_en.
REQ-029 With pc_en=0, pc_next SHALL equal pc_q.
REQ-030 pc_q+PC_STEP SHALL wrap modulo 2^32 (32'hFFFFFFFC+4 -> 32'h0).
REQ-031 Zero-wait memory throughput SHALL be one instruction per two cycles.

Reset
REQ-032 With rst=1 at posedge: state=IDLE, imem_req=0, imem_addr=0, inst_valid=0, inst_out=0, inst_pc=0.
REQ-033 While rst=1, pc_en SHALL be 0 and redirect, stall and imem_ack SHALL be ignored.
REQ-034 Reset during WAIT SHALL abandon the outstanding request without waiting for ack.

Configuration
REQ-035 With macro FETCH_PERF_EN defined, the block SHALL add output perf_cnt [31:0], counting accepted instructions (HOLD and stall=0 and redirect=0), reset to 0, wrapping at 2^32.
REQ-036 Without FETCH_PERF_EN, the perf_cnt port and its counter SHALL be absent, with functional behaviour identical.

Verification
REQ-037 Reset release, pc_q=0, ack zero-wait, rdata=32'h20080005, stall=0: imem_req at cycle 1 with addr 0; inst_valid=1, inst_out=32'h20080005, inst_pc=0 at cycle 2; pc_en pulse with pc_next=4 at cycle 1.
REQ-038 HOLD with stall=1 for 5 cycles: inst_valid, inst_out and inst_pc constant, imem_req=0, pc_en=0 throughout.
REQ-039 WAIT at addr 8 with ack delayed, redirect to 32'h100: pc_en=1 and pc_next=32'h100 that cycle; DROP until ack; stale data not presented; next request addr 32'h100.
REQ-040 redirect coincident with ack and with stall=1: data discarded, pc_next=redirect_pc, next state IDLE.
REQ-041 pc_q=32'hFFFFFFFC fetch completes: pc_next=32'h0.
REQ-042 FETCH_PERF_EN defined, 3 instructions accepted and 1 redirected away: perf_cnt=3.
